pattern_line_rx: RTL and testbench

- Receive-side counterpart of the 8-bit bidirectional data-line pattern transmitter.
- Samples the shared 8-bit line while the far end owns it and synchronises the bytes.
- Acquires and tracks the repeating three-byte test sequence (F0, 0F, 3C), counts sequence errors and hands each received byte to downstream logic over a valid/ready interface.
- Sits at the line pins, opposite the transmitter, for bring-up and link checking.

---
 rtl/pattern_line_rx_pkg.sv | 31 +++
 rtl/pattern_line_rx_if.sv | 10 +
 rtl/line_sync8.sv | 38 +++
 rtl/pattern_line_rx.sv | 188 ++++++++++++++++++
 tb/tb_pattern_line_rx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_line_rx_pkg.sv
// Shared types, default pattern bytes and pattern-index helpers for pattern_line_rx.
package pattern_line_rx_pkg;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StCheck  = 2'd1,
        StLocked = 2'd2
    } state_e;

    localparam logic [7:0] DefPat0 = 8'hF0;
    localparam logic [7:0] DefPat1 = 8'h0F;
    localparam logic [7:0] DefPat2 = 8'h3C;

    // Index value meaning "byte is not part of the sequence".
    localparam logic [1:0] IdxNone = 2'd3;

    // Map a byte to its position in the three-byte sequence, or IdxNone.
    function automatic logic [1:0] pat_index(input logic [7:0] b, input logic [7:0] p0,
                                             input logic [7:0] p1, input logic [7:0] p2);
        if (b == p0) return 2'd0;
        else if (b == p1) return 2'd1;
        else if (b == p2) return 2'd2;
        else return IdxNone;
    endfunction

    // Sequence position following i, wrapping 2 -> 0.
    function automatic logic [1:0] next_index(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/pattern_line_rx_if.sv
// Valid/ready byte stream carrying received bytes and their match flag downstream.
interface pattern_line_rx_if;
    logic [7:0] rx_data;
    logic       rx_match;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_match, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_match, input rx_valid, output rx_ready);
endinterface

// File: rtl/line_sync8.sv
// Two-flop synchroniser for the 8-bit data line plus its qualifying enable.
module line_sync8 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       en_i,
    output logic [7:0] data_o,
    output logic       en_o
);
    logic [7:0] d1_q, d1_d, d2_q, d2_d;
    logic       e1_q, e1_d, e2_q, e2_d;

    // Shift both stages; the enable travels alongside its data.
    always_comb begin
        d1_d = data_i;
        e1_d = en_i;
        d2_d = d1_q;
        e2_d = e1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d1_q <= 8'h00;
            d2_q <= 8'h00;
            e1_q <= 1'b0;
            e2_q <= 1'b0;
        end else begin
            d1_q <= d1_d;
            d2_q <= d2_d;
            e1_q <= e1_d;
            e2_q <= e2_d;
        end
    end

    assign data_o = d2_q;
    assign en_o   = e2_q;
endmodule

// File: rtl/pattern_line_rx.sv
// Receiver for the repeating F0/0F/3C line test sequence: synchronises the line, tracks lock,
// counts errors and presents each byte on a valid/ready stream.
// Optional macro PATTERN_LINE_RX_LOOPBACK_EN adds lb_oe_i to drive the last byte back out.
module pattern_line_rx
    import pattern_line_rx_pkg::*;
#(
    parameter logic [7:0]  PAT0        = DefPat0,
    parameter logic [7:0]  PAT1        = DefPat1,
    parameter logic [7:0]  PAT2        = DefPat2,
    parameter int unsigned LOCK_COUNT  = 3,
    parameter int unsigned UNLOCK_ERRS = 2,
    parameter int unsigned ERR_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    inout  wire  [7:0]         data_line_io,
    input  logic               rx_en_i,
    input  logic               clr_i,
`ifdef PATTERN_LINE_RX_LOOPBACK_EN
    input  logic               lb_oe_i,
`endif
    pattern_line_rx_if.master  rx_if,
    output logic               locked_o,
    output logic [ERR_W-1:0]   err_cnt_o,
    output logic               overflow_o
);
    localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned ConsW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [GoodW-1:0] LockCnt   = GoodW'(LOCK_COUNT);
    localparam logic [ConsW-1:0] UnlockCnt = ConsW'(UNLOCK_ERRS);

    logic [7:0] s_data;
    logic       s_taken;

    line_sync8 u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (data_line_io),
        .en_i   (rx_en_i),
        .data_o (s_data),
        .en_o   (s_taken)
    );

    state_e           state_q, state_d;
    logic [1:0]       exp_q, exp_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [ConsW-1:0] cons_q, cons_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       data_q, data_d;
    logic             match_q, match_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic [7:0]       exp_byte;
    logic [1:0]       hit;
    logic             is_match;

    // Sequence tracking, error counting and output handshake.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        good_d   = good_q;
        cons_d   = cons_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        data_d   = data_q;
        match_d  = match_q;
        valid_d  = valid_q;
        case (exp_q)
            2'd0:    exp_byte = PAT0;
            2'd1:    exp_byte = PAT1;
            default: exp_byte = PAT2;
        endcase
        is_match = (s_data == exp_byte);
        hit      = pat_index(s_data, PAT0, PAT1, PAT2);

        if (valid_q && rx_if.rx_ready) valid_d = 1'b0;

        if (s_taken) begin
            // Held byte wins over a new one when downstream has not accepted it.
            if (!valid_q || rx_if.rx_ready) begin
                data_d  = s_data;
                match_d = is_match;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end

            case (state_q)
                StHunt: begin
                    if (hit != IdxNone) begin
                        exp_d   = next_index(hit);
                        good_d  = GoodW'(1);
                        cons_d  = '0;
                        state_d = (LOCK_COUNT == 1) ? StLocked : StCheck;
                    end
                end
                StCheck: begin
                    if (is_match) begin
                        good_d = good_q + GoodW'(1);
                        exp_d  = next_index(exp_q);
                        if (good_d == LockCnt) begin
                            state_d = StLocked;
                            cons_d  = '0;
                        end
                    end else if (hit != IdxNone) begin
                        // Re-acquire on this same byte rather than waiting for the next.
                        good_d = GoodW'(1);
                        exp_d  = next_index(hit);
                    end else begin
                        state_d = StHunt;
                    end
                end
                StLocked: begin
                    exp_d = next_index(exp_q);
                    if (is_match) begin
                        cons_d = '0;
                    end else begin
                        if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
                        cons_d = cons_q + ConsW'(1);
                        if (cons_d == UnlockCnt) state_d = StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        if (clr_i) begin
            err_d = '0;
            ovf_d = 1'b0;
        end
        locked_d = (state_d == StLocked);
    end

    // Single state register for the tracker and its registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StHunt;
            exp_q    <= 2'd0;
            good_q   <= '0;
            cons_q   <= '0;
            err_q    <= '0;
            ovf_q    <= 1'b0;
            data_q   <= 8'h00;
            match_q  <= 1'b0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            cons_q   <= cons_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            match_q  <= match_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_match = match_q;
    assign rx_if.rx_valid = valid_q;
    assign locked_o       = locked_q;
    assign err_cnt_o      = err_q;
    assign overflow_o     = ovf_q;

`ifdef PATTERN_LINE_RX_LOOPBACK_EN
    logic [7:0] last_q, last_d;

    // Remember the most recent taken byte for loopback.
    always_comb begin
        last_d = s_taken ? s_data : last_q;
    end

    // Loopback byte register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= 8'h00;
        else       last_q <= last_d;
    end

    // Sampling has priority: never drive while the far end owns the line.
    assign data_line_io = (lb_oe_i && !rx_en_i) ? last_q : 8'bz;
`else
    assign data_line_io = 8'bz;
`endif
endmodule

// File: tb/tb_pattern_line_rx.sv
// Directed bench for pattern_line_rx: table-driven stream plus hand-written corner sequences.
module tb_pattern_line_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b0;
    logic       clr = 1'b0;
    logic       rdy = 1'b1;
    logic [7:0] tb_line = 8'h00;
    logic       tb_oe = 1'b1;
    wire  [7:0] data_line;
    logic       lock1, lock2, ovf1, ovf2;
    logic [7:0] err1;
    logic [1:0] err2;
    int         checks = 0;
    int         errors = 0;

    assign data_line = tb_oe ? tb_line : 8'bz;

    pattern_line_rx_if rx_if1 ();
    pattern_line_rx_if rx_if2 ();
    assign rx_if1.rx_ready = rdy;
    assign rx_if2.rx_ready = 1'b1;

`ifdef PATTERN_LINE_RX_LOOPBACK_EN
    logic lb_oe = 1'b0;
`endif

    pattern_line_rx dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_line_io (data_line),
        .rx_en_i      (rx_en),
        .clr_i        (clr),
`ifdef PATTERN_LINE_RX_LOOPBACK_EN
        .lb_oe_i      (lb_oe),
`endif
        .rx_if        (rx_if1),
        .locked_o     (lock1),
        .err_cnt_o    (err1),
        .overflow_o   (ovf1)
    );

    pattern_line_rx #(.ERR_W(2)) dut2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_line_io (data_line),
        .rx_en_i      (rx_en),
        .clr_i        (clr),
`ifdef PATTERN_LINE_RX_LOOPBACK_EN
        .lb_oe_i      (1'b0),
`endif
        .rx_if        (rx_if2),
        .locked_o     (lock2),
        .err_cnt_o    (err2),
        .overflow_o   (ovf2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] line;
        logic       en;
        logic       rdy;
        logic       clr;
        logic       valid;
        logic [7:0] data;
        logic       match;
        logic       locked;
        logic [7:0] err;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] line, input logic en, input logic r,
                                input logic c, input logic v, input logic [7:0] d,
                                input logic m, input logic l, input logic [7:0] e,
                                input logic o);
        vec_t x;
        x.line = line; x.en = en; x.rdy = r; x.clr = c;
        x.valid = v; x.data = d; x.match = m; x.locked = l; x.err = e; x.ovf = o;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, {31'd0, rx_if1.rx_valid}, 32'd0);
        check({tag, " data"}, {24'd0, rx_if1.rx_data}, 32'd0);
        check({tag, " match"}, {31'd0, rx_if1.rx_match}, 32'd0);
        check({tag, " locked"}, {31'd0, lock1}, 32'd0);
        check({tag, " err"}, {24'd0, err1}, 32'd0);
        check({tag, " ovf"}, {31'd0, ovf1}, 32'd0);
        check({tag, " locked2"}, {31'd0, lock2}, 32'd0);
        check({tag, " err2"}, {30'd0, err2}, 32'd0);
    endtask

    initial begin
        logic [7:0] seq[11];

        // Outputs reflect the byte applied two rows earlier (2 sync stages + output register).
        //                 line  en    rdy   clr   valid data  match lock  err   ovf
        tbl.push_back(mk(8'hF0,1'b1,1'b1,1'b0, 1'b0,8'h00,1'b0,1'b0,8'd0,1'b0));
        tbl.push_back(mk(8'h0F,1'b1,1'b1,1'b0, 1'b0,8'h00,1'b0,1'b0,8'd0,1'b0));
        tbl.push_back(mk(8'h3C,1'b1,1'b1,1'b0, 1'b1,8'hF0,1'b1,1'b0,8'd0,1'b0));
        tbl.push_back(mk(8'hF0,1'b1,1'b1,1'b0, 1'b1,8'h0F,1'b1,1'b0,8'd0,1'b0));
        tbl.push_back(mk(8'hAA,1'b1,1'b1,1'b0, 1'b1,8'h3C,1'b1,1'b1,8'd0,1'b0));
        tbl.push_back(mk(8'h3C,1'b1,1'b1,1'b0, 1'b1,8'hF0,1'b1,1'b1,8'd0,1'b0));
        tbl.push_back(mk(8'hF0,1'b1,1'b1,1'b0, 1'b1,8'hAA,1'b0,1'b1,8'd1,1'b0));
        tbl.push_back(mk(8'hAA,1'b1,1'b1,1'b0, 1'b1,8'h3C,1'b1,1'b1,8'd1,1'b0));
        tbl.push_back(mk(8'hAA,1'b1,1'b1,1'b0, 1'b1,8'hF0,1'b1,1'b1,8'd1,1'b0));
        tbl.push_back(mk(8'hF0,1'b1,1'b1,1'b0, 1'b1,8'hAA,1'b0,1'b1,8'd2,1'b0));
        tbl.push_back(mk(8'h0F,1'b1,1'b1,1'b0, 1'b1,8'hAA,1'b0,1'b0,8'd3,1'b0));
        tbl.push_back(mk(8'h3C,1'b1,1'b1,1'b0, 1'b1,8'hF0,1'b1,1'b0,8'd3,1'b0));
        tbl.push_back(mk(8'hAA,1'b0,1'b1,1'b0, 1'b1,8'h0F,1'b1,1'b0,8'd3,1'b0));
        tbl.push_back(mk(8'hAA,1'b0,1'b1,1'b0, 1'b1,8'h3C,1'b1,1'b1,8'd3,1'b0));
        tbl.push_back(mk(8'h00,1'b0,1'b1,1'b0, 1'b0,8'h3C,1'b1,1'b1,8'd3,1'b0));
        tbl.push_back(mk(8'hF0,1'b1,1'b0,1'b0, 1'b0,8'h3C,1'b1,1'b1,8'd3,1'b0));
        tbl.push_back(mk(8'h0F,1'b1,1'b0,1'b0, 1'b0,8'h3C,1'b1,1'b1,8'd3,1'b0));
        tbl.push_back(mk(8'hAA,1'b0,1'b0,1'b0, 1'b1,8'hF0,1'b1,1'b1,8'd3,1'b0));
        tbl.push_back(mk(8'hAA,1'b0,1'b0,1'b0, 1'b1,8'hF0,1'b1,1'b1,8'd3,1'b1));
        tbl.push_back(mk(8'hAA,1'b0,1'b1,1'b0, 1'b0,8'hF0,1'b1,1'b1,8'd3,1'b1));
        tbl.push_back(mk(8'hAA,1'b0,1'b1,1'b1, 1'b0,8'hF0,1'b1,1'b1,8'd0,1'b0));
        tbl.push_back(mk(8'h55,1'b1,1'b1,1'b0, 1'b0,8'hF0,1'b1,1'b1,8'd0,1'b0));
        tbl.push_back(mk(8'h55,1'b1,1'b1,1'b0, 1'b0,8'hF0,1'b1,1'b1,8'd0,1'b0));
        tbl.push_back(mk(8'h0F,1'b1,1'b1,1'b0, 1'b1,8'h55,1'b0,1'b1,8'd1,1'b0));
        tbl.push_back(mk(8'h3C,1'b1,1'b1,1'b0, 1'b1,8'h55,1'b0,1'b0,8'd2,1'b0));
        tbl.push_back(mk(8'h3C,1'b1,1'b1,1'b0, 1'b1,8'h0F,1'b1,1'b0,8'd2,1'b0));
        tbl.push_back(mk(8'hF0,1'b1,1'b1,1'b0, 1'b1,8'h3C,1'b1,1'b0,8'd2,1'b0));
        tbl.push_back(mk(8'h0F,1'b1,1'b1,1'b0, 1'b1,8'h3C,1'b0,1'b0,8'd2,1'b0));
        tbl.push_back(mk(8'h00,1'b0,1'b1,1'b0, 1'b1,8'hF0,1'b1,1'b0,8'd2,1'b0));
        tbl.push_back(mk(8'h00,1'b0,1'b1,1'b0, 1'b1,8'h0F,1'b1,1'b1,8'd2,1'b0));
        tbl.push_back(mk(8'h00,1'b0,1'b1,1'b0, 1'b0,8'h0F,1'b1,1'b1,8'd2,1'b0));

        // Reset state while reset is held.
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Main table: lock, single error, unlock/relock, overflow, clear, re-hunt in CHECK.
        for (int i = 0; i < tbl.size(); i++) begin
            tb_line = tbl[i].line;
            rx_en   = tbl[i].en;
            rdy     = tbl[i].rdy;
            clr     = tbl[i].clr;
            tick();
            check($sformatf("row%0d valid", i), {31'd0, rx_if1.rx_valid}, {31'd0, tbl[i].valid});
            check($sformatf("row%0d data", i), {24'd0, rx_if1.rx_data}, {24'd0, tbl[i].data});
            check($sformatf("row%0d match", i), {31'd0, rx_if1.rx_match}, {31'd0, tbl[i].match});
            check($sformatf("row%0d locked", i), {31'd0, lock1}, {31'd0, tbl[i].locked});
            check($sformatf("row%0d err", i), {24'd0, err1}, {24'd0, tbl[i].err});
            check($sformatf("row%0d ovf", i), {31'd0, ovf1}, {31'd0, tbl[i].ovf});
        end
        check("lock2 after table", {31'd0, lock2}, 32'd1);
        check("err2 after table", {30'd0, err2}, 32'd2);

        // Locked, expected index 2: five mismatches each followed by a match keep lock;
        // the 2-bit counter saturates at 3 while the 8-bit one reaches 7.
        seq = '{8'h3C, 8'hAA, 8'h0F, 8'hAA, 8'hF0, 8'hAA, 8'h3C, 8'hAA, 8'h0F, 8'hAA, 8'hF0};
        for (int i = 0; i < 13; i++) begin
            tb_line = (i < 11) ? seq[i] : 8'h00;
            rx_en   = (i < 11);
            tick();
            if (i == 7) begin
                check("sat mid err1", {24'd0, err1}, 32'd5);
                check("sat mid err2", {30'd0, err2}, 32'd3);
                check("sat mid match", {31'd0, rx_if1.rx_match}, 32'd0);
            end
            if (i == 12) begin
                check("sat end err1", {24'd0, err1}, 32'd7);
                check("sat end err2", {30'd0, err2}, 32'd3);
                check("sat end lock1", {31'd0, lock1}, 32'd1);
                check("sat end lock2", {31'd0, lock2}, 32'd1);
                check("sat end data", {24'd0, rx_if1.rx_data}, 32'hF0);
                check("sat end match", {31'd0, rx_if1.rx_match}, 32'd1);
            end
        end

        // Asynchronous reset in mid-cycle clears outputs before any clock edge.
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async rst");
        tick();
        rst = 1'b0;

`ifdef PATTERN_LINE_RX_LOOPBACK_EN
        // Loopback drives 0 after reset, then the last captured byte; sampling has priority.
        tb_oe = 1'b0;
        rx_en = 1'b0;
        lb_oe = 1'b1;
        #1;
        check("lb after reset", {24'd0, data_line}, 32'h00);
        lb_oe   = 1'b0;
        tb_oe   = 1'b1;
        tb_line = 8'h3C;
        rx_en   = 1'b1;
        tick();
        rx_en = 1'b0;
        tick();
        tick();
        tb_oe = 1'b0;
        lb_oe = 1'b1;
        #1;
        check("lb drives 3C", {24'd0, data_line}, 32'h3C);
        rx_en   = 1'b1;
        tb_oe   = 1'b1;
        tb_line = 8'h55;
        #1;
        check("lb released", {24'd0, data_line}, 32'h55);
        lb_oe = 1'b0;
        rx_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
